// File: rtl/delay_arb_pkg.sv
// Shared types and constants for the delay timer arbiter.
package delay_arb_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/delay_timer_arbiter_down_cnt.sv
// Loadable down counter that saturates at zero; resets to all ones.
module down_cnt #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] count,
  output logic             zero
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count_reg <= '1;
    else if (load)
      count_reg <= din;
    else if (en && (count_reg != '0))
      count_reg <= count_reg - WIDTH'(1);
  end

  assign count = count_reg;
  assign zero  = (count_reg == '0);

endmodule

// File: rtl/delay_timer_arbiter.sv
// Two-requester arbiter sharing one prescaled delay counter.
// Optional DELAY_ARB_ABORT_EN: granted requester may cancel by dropping req.
module delay_timer_arbiter
  import delay_arb_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] val0,
  input  logic [WIDTH-1:0] val1,
  input  logic             tick,
  output logic [1:0]       gnt,
  output logic [1:0]       done,
  output logic [WIDTH-1:0] count,
  output logic             busy
);

  state_t           state_reg, state_next;
  logic [1:0]       gnt_reg, gnt_next;
  logic [1:0]       done_reg, done_next;
  logic             ptr_reg, ptr_next;
  logic             win_idx;
  logic [1:0]       win_onehot;
  logic [WIDTH-1:0] vals [2];
  logic             served_idx;
  logic             cnt_load, cnt_en, cnt_zero;

  // Single requester wins outright; a tie goes to the round-robin pointer.
  assign win_idx    = req[1] & (~req[0] | ptr_reg);
  assign served_idx = gnt_reg[1];
  assign vals[0]    = val0;
  assign vals[1]    = val1;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_win
      assign win_onehot[gi] = (gi == 1) ? win_idx : ~win_idx;
    end
  endgenerate

  down_cnt #(.WIDTH(WIDTH)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .load  (cnt_load),
    .en    (cnt_en),
    .din   (vals[win_idx]),
    .count (count),
    .zero  (cnt_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      gnt_reg   <= '0;
      done_reg  <= '0;
      ptr_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      gnt_reg   <= gnt_next;
      done_reg  <= done_next;
      ptr_reg   <= ptr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (req != 2'b00) state_next = COUNT;
      COUNT: begin
`ifdef DELAY_ARB_ABORT_EN
        if (!req[served_idx]) state_next = IDLE;
        else
`endif
        if (tick && cnt_zero) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Leaving COUNT or DONE for IDLE always hands priority to the other requester.
  always_comb begin
    gnt_next  = gnt_reg;
    done_next = 2'b00;
    ptr_next  = ptr_reg;
    cnt_load  = 1'b0;
    cnt_en    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req != 2'b00) begin
          gnt_next = win_onehot;
          cnt_load = 1'b1;
        end
      end
      COUNT: begin
        if (state_next == IDLE) begin
          gnt_next = 2'b00;
          ptr_next = ~served_idx;
        end else if (state_next == DONE) begin
          done_next = gnt_reg;
        end else begin
          cnt_en = tick;
        end
      end
      DONE: begin
        gnt_next = 2'b00;
        ptr_next = ~served_idx;
      end
      default: gnt_next = 2'b00;
    endcase
  end

  assign gnt  = gnt_reg;
  assign done = done_reg;
  assign busy = (state_reg != IDLE);

endmodule
